// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first. Divides the system clock down to
// the bit period, samples the synchronized line at mid-bit and strobes each byte.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          rxd_m;
  logic          rxd_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Receive state machine with registered strobes and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shift       <= 8'h00;
      data        <= 8'h00;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= START;
          end else begin
            busy <= 1'b0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              // Line went back high before mid-start: treat as noise.
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= 3'd0;
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rxd_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              // Returning to IDLE mid-stop-bit lets a back-to-back start be seen.
              data       <= shift;
              data_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxd_s) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
